btb_update_unit: RTL and testbench

- Write side of the 2-way, 8-set branch target buffer; the IF-stage lookup only reads it.
- Accepts resolved-branch records from EX through a valid/ready handshake and buffers them in a small FIFO.
- Performs a read-modify-write on the selected BTB set: 2-bit predictor state update, target refresh, allocation with LRU victim selection, and LRU bit update.

---
 rtl/btb_update_unit.sv | 212 +++++++++++++++++++++
 tb/tb_btb_update_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_unit.sv
// rtl/btb_update_unit.sv - BTB write side: update FIFO plus read-modify-write of one set
// Hits refresh state/target, taken misses allocate over the LRU victim, not-taken misses write nothing.
module btb_update_unit #(
  parameter int         FIFO_DEPTH  = 2,
  parameter logic [1:0] ALLOC_STATE = 2'b11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [31:0]  upd_pc,
  input  logic [31:0]  upd_target,
  input  logic         upd_taken,
  output logic [2:0]   rd_index,
  input  logic [127:0] rd_set,
  output logic         wr_en,
  output logic [2:0]   wr_index,
  output logic [127:0] wr_set,
  output logic         lru_wr_en,
  output logic [2:0]   lru_wr_index,
  output logic         lru_wr_value,
  output logic         busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  state_e state_q, state_d;

  logic [29:0]   fifo_pc_q  [FIFO_DEPTH];
  logic [31:0]   fifo_tgt_q [FIFO_DEPTH];
  logic          fifo_tk_q  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Popped record, pc kept as pc[31:2] so [2:0] is the set index and [29:3] the tag.
  logic [29:0]  cur_pc_q, cur_pc_d;
  logic [31:0]  cur_tgt_q, cur_tgt_d;
  logic         cur_tk_q, cur_tk_d;

  logic         wr_en_q, wr_en_d;
  logic [2:0]   wr_index_q, wr_index_d;
  logic [127:0] wr_set_q, wr_set_d;
  logic         lru_val_q, lru_val_d;
  logic [7:0]   shadow_q, shadow_d;

  logic         full, empty, push, pop;
  logic [63:0]  way1, way2, alloc_way;
  logic [26:0]  cur_tag;
  logic [2:0]   cur_idx;
  logic         hit1, hit2, vic_way2, do_write, new_lru;
  logic [127:0] new_set;
  logic         unused_pc_bits;

  assign unused_pc_bits = ^upd_pc[1:0];

  function automatic logic [1:0] pred_next(input logic [1:0] s, input logic tk);
    case ({tk, s})
      3'b1_00: pred_next = 2'b01;
      3'b1_01: pred_next = 2'b11;
      3'b1_11: pred_next = 2'b10;
      3'b1_10: pred_next = 2'b10;
      3'b0_10: pred_next = 2'b11;
      3'b0_11: pred_next = 2'b01;
      3'b0_01: pred_next = 2'b00;
      default: pred_next = 2'b00;
    endcase
  endfunction

  function automatic logic [63:0] hit_way(input logic [63:0] w, input logic tk, input logic [31:0] tgt);
    hit_way = {w[63:36], tk ? tgt : w[35:4], pred_next(w[3:2], tk), 2'b00};
  endfunction

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign upd_ready = !full;
  assign push      = upd_valid && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = empty ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    rd_index = 3'd0;
    busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        pop  = !empty;
        busy = !empty;
      end
      READ:    rd_index = cur_pc_q[2:0];
      WRITE:   pop = !empty;
      default: ;
    endcase
  end

  assign wr_en        = wr_en_q;
  assign wr_index     = wr_index_q;
  assign wr_set       = wr_set_q;
  assign lru_wr_en    = wr_en_q;
  assign lru_wr_index = wr_index_q;
  assign lru_wr_value = lru_val_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= upd_pc[31:2];
      fifo_tgt_q[wr_ptr_q] <= upd_target;
      fifo_tk_q[wr_ptr_q]  <= upd_taken;
    end
  end

  always_comb begin
    way1      = rd_set[127:64];
    way2      = rd_set[63:0];
    cur_tag   = cur_pc_q[29:3];
    cur_idx   = cur_pc_q[2:0];
    hit1      = way1[63] && (way1[62:36] == cur_tag);
    hit2      = !hit1 && way2[63] && (way2[62:36] == cur_tag);
    alloc_way = {1'b1, cur_tag, cur_tgt_q, ALLOC_STATE, 2'b00};
    // Shadow bit 0 means way1 was written last, so way2 is the LRU victim.
    vic_way2  = way1[63] && (!way2[63] || !shadow_q[cur_idx]);
    new_set   = rd_set;
    new_lru   = 1'b0;
    do_write  = 1'b1;
    if (hit1) begin
      new_set[127:64] = hit_way(way1, cur_tk_q, cur_tgt_q);
    end else if (hit2) begin
      new_set[63:0] = hit_way(way2, cur_tk_q, cur_tgt_q);
      new_lru       = 1'b1;
    end else if (cur_tk_q) begin
      if (vic_way2) begin
        new_set[63:0] = alloc_way;
        new_lru       = 1'b1;
      end else begin
        new_set[127:64] = alloc_way;
      end
    end else begin
      do_write = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cur_pc_d   = cur_pc_q;
    cur_tgt_d  = cur_tgt_q;
    cur_tk_d   = cur_tk_q;
    wr_en_d    = 1'b0;
    wr_index_d = wr_index_q;
    wr_set_d   = wr_set_q;
    lru_val_d  = lru_val_q;
    shadow_d   = shadow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      cur_pc_d  = fifo_pc_q[rd_ptr_q];
      cur_tgt_d = fifo_tgt_q[rd_ptr_q];
      cur_tk_d  = fifo_tk_q[rd_ptr_q];
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    if (state_q == READ) begin
      wr_en_d    = do_write;
      wr_index_d = cur_idx;
      wr_set_d   = new_set;
      lru_val_d  = new_lru;
    end
    if (wr_en_q) shadow_d[wr_index_q] = lru_val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_pc_q   <= '0;
      cur_tgt_q  <= '0;
      cur_tk_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_index_q <= '0;
      wr_set_q   <= '0;
      lru_val_q  <= 1'b0;
      shadow_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_pc_q   <= cur_pc_d;
      cur_tgt_q  <= cur_tgt_d;
      cur_tk_q   <= cur_tk_d;
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_set_q   <= wr_set_d;
      lru_val_q  <= lru_val_d;
      shadow_q   <= shadow_d;
    end
  end
endmodule

// File: tb/tb_btb_update_unit.sv
// tb/tb_btb_update_unit.sv - self-checking bench for btb_update_unit
// A reference BTB and an in-order 2-cycle schedule predict every output each cycle.
module tb_btb_update_unit;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         upd_valid, upd_ready, upd_taken;
  logic [31:0]  upd_pc, upd_target;
  logic [2:0]   rd_index, wr_index, lru_wr_index;
  logic [127:0] rd_set, wr_set;
  logic         wr_en, lru_wr_en, lru_wr_value, busy;

  btb_update_unit #(.FIFO_DEPTH(DEPTH), .ALLOC_STATE(2'b11)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .rd_index(rd_index), .rd_set(rd_set),
    .wr_en(wr_en), .wr_index(wr_index), .wr_set(wr_set),
    .lru_wr_en(lru_wr_en), .lru_wr_index(lru_wr_index), .lru_wr_value(lru_wr_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // BTB file emulation: combinational read, write on the strobe.
  logic [127:0] btb_mem [8] = '{default: '0};
  assign rd_set = btb_mem[rd_index];
  always @(posedge clk) if (wr_en) btb_mem[wr_index] <= wr_set;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } upd_t;
  upd_t         q[$];
  logic [127:0] ref_btb [8] = '{default: '0};
  logic [7:0]   ref_lru;
  int           last_s = -100;
  logic         p_we, p_lru;
  logic [2:0]   p_idx, p_rd;
  logic [127:0] p_set;
  bit           exp_ready = 1, exp_busy = 0, in_read = 0, in_write = 0;

  // Predictor as a 0..3 confidence level encoded 00,01,11,10.
  function automatic logic [1:0] sat(input logic [1:0] s, input logic tk);
    logic [1:0] enc [4];
    int lvl;
    enc[0] = 2'b00; enc[1] = 2'b01; enc[2] = 2'b11; enc[3] = 2'b10;
    lvl = 0;
    for (int k = 0; k < 4; k++) if (enc[k] == s) lvl = k;
    lvl = tk ? ((lvl < 3) ? lvl + 1 : 3) : ((lvl > 0) ? lvl - 1 : 0);
    return enc[lvl];
  endfunction

  function automatic void ref_calc(input logic [127:0] s, input logic [31:0] pc, input logic [31:0] tgt,
                                   input logic tk, input logic lru,
                                   output logic we, output logic [127:0] ns, output logic lv);
    logic [63:0] w [2];
    logic [26:0] tag;
    int hit, vic;
    w[0] = s[127:64];
    w[1] = s[63:0];
    tag  = pc[31:5];
    hit  = -1;
    for (int k = 1; k >= 0; k--) if (w[k][63] && w[k][62:36] == tag) hit = k;
    we = 1'b1;
    lv = 1'b0;
    if (hit >= 0) begin
      w[hit][3:2] = sat(w[hit][3:2], tk);
      if (tk) w[hit][35:4] = tgt;
      lv = (hit == 1);
    end else if (tk) begin
      if (!w[0][63])      vic = 0;
      else if (!w[1][63]) vic = 1;
      else                vic = lru ? 0 : 1;
      w[vic] = {1'b1, tag, tgt, 2'b11, 2'b00};
      lv = (vic == 1);
    end else begin
      we = 1'b0;
    end
    ns = {w[0], w[1]};
  endfunction

  initial begin
    int   n;
    upd_t u;
    ref_lru = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        last_s = -100;
        p_we = 1'b0;
        ref_lru = '0;
        exp_ready = 1; in_read = 0; in_write = 0; exp_busy = 0;
      end else begin
        n = cyc + 1;
        if (last_s + 2 == n && p_we) begin
          ref_btb[p_idx] = p_set;
          ref_lru[p_idx] = p_lru;
        end
        if (q.size() > 0 && n >= last_s + 2) begin
          u = q.pop_front();
          p_idx = u.pc[4:2];
          p_rd  = p_idx;
          ref_calc(ref_btb[p_idx], u.pc, u.tgt, u.tk, ref_lru[p_idx], p_we, p_set, p_lru);
          last_s = n;
        end
        if (upd_valid && exp_ready) q.push_back('{upd_pc, upd_target, upd_taken});
        exp_ready = (q.size() < DEPTH);
        in_read   = (last_s == n);
        in_write  = (last_s + 1 == n);
        exp_busy  = (q.size() > 0) || in_read || in_write;
      end
    end
  end

  logic [127:0] log_set[$];
  int           log_cyc[$];
  logic         log_lru[$];
  logic [2:0]   log_idx[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && chk_en) begin
        chk("upd_ready", upd_ready, exp_ready);
        chk("busy", busy, exp_busy);
        chk("wr_en", wr_en, in_write && p_we);
        chk("lru_wr_en", lru_wr_en, in_write && p_we);
        if (in_write && p_we) begin
          chk("wr_index", wr_index, p_idx);
          chk("lru_wr_index", lru_wr_index, p_idx);
          chk("wr_set", wr_set, p_set);
          chk("lru_wr_value", lru_wr_value, p_lru);
        end
        if (in_read) chk("rd_index_read", rd_index, p_rd);
        if (!in_read && !in_write) chk("rd_index_idle", rd_index, 3'd0);
      end
      if (!rst && wr_en) begin
        log_set.push_back(wr_set);
        log_cyc.push_back(cyc);
        log_lru.push_back(lru_wr_value);
        log_idx.push_back(wr_index);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, output int acc);
    bit got;
    got = 0;
    acc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
      got = upd_ready;
      @(posedge clk);
      #1;
    end
    if (got) acc = cyc;
    else begin
      checks++; errors++;
      $display("FAIL push_timeout: pc %h not accepted within 20 cycles", pc);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] exp_st [7] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};

  initial begin
    int a, base;
    int acc [4];
    logic [127:0] s;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_lru_wr_en", lru_wr_en, 1'b0);
    chk("rst_wr_index", wr_index, 3'd0);
    chk("rst_wr_set", wr_set, 128'd0);
    chk("rst_lru_wr_value", lru_wr_value, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_upd_ready", upd_ready, 1'b1);
    rst = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // Single allocation into an empty set
    base = log_set.size();
    push(32'h0000_1008, 32'h0000_2000, 1'b1, a);
    idle(6);
    chk("t1_write_count", log_set.size() - base, 1);
    if (log_set.size() > base) begin
      chk("t1_latency", log_cyc[base] - a, 2);
      chk("t1_index", log_idx[base], 3'd2);
      chk("t1_set", log_set[base], {64'h8000_0800_0002_000C, 64'h0});
      chk("t1_lru", log_lru[base], 1'b0);
    end

    // Saturation up then down; not-taken targets must not stick
    base = log_set.size();
    for (int i = 0; i < 7; i++) push(32'h0000_1008, (i < 3) ? 32'h0000_2000 : 32'h0000_BAD0, (i < 3), a);
    idle(8);
    chk("t2_write_count", log_set.size() - base, 7);
    if (log_set.size() >= base + 7) begin
      for (int i = 0; i < 7; i++) begin
        s = log_set[base + i];
        chk($sformatf("t2_state_%0d", i), s[67:66], exp_st[i]);
        chk($sformatf("t2_target_%0d", i), s[99:68], 32'h0000_2000);
      end
    end

    // Replacement: B fills way2, A hit makes way1 recent, C evicts B
    base = log_set.size();
    push(32'h0000_1028, 32'h0000_2800, 1'b1, a);
    push(32'h0000_1008, 32'h0000_2000, 1'b1, a);
    push(32'h0000_1048, 32'h0000_3000, 1'b1, a);
    idle(10);
    chk("t3_write_count", log_set.size() - base, 3);
    if (log_set.size() >= base + 3) begin
      chk("t3_b_lru", log_lru[base], 1'b1);
      chk("t3_a_lru", log_lru[base + 1], 1'b0);
      chk("t3_c_set", log_set[base + 2], {64'h8000_0800_0002_0004, 64'h8000_0820_0003_000C});
      chk("t3_c_lru", log_lru[base + 2], 1'b1);
    end

    // Not-taken miss: no write, busy spans READ and WRITE only
    base = log_set.size();
    push(32'h0000_0010, 32'h0000_4000, 1'b0, a);
    idle(2);
    chk("t4_busy_write_cycle", busy, 1'b1);
    @(negedge clk);
    chk("t4_busy_done", busy, 1'b0);
    idle(4);
    chk("t4_no_write", log_set.size() - base, 0);

    // Backpressure: FIFO fills, a full cycle blocks the push despite the pop
    base = log_set.size();
    push(32'h0000_0014, 32'h0000_5000, 1'b1, acc[0]);
    push(32'h0000_0018, 32'h0000_6000, 1'b1, acc[1]);
    push(32'h0000_001C, 32'h0000_7000, 1'b1, acc[2]);
    push(32'h0000_0034, 32'h0000_8000, 1'b1, acc[3]);
    idle(10);
    chk("t5_acc2", acc[2] - acc[0], 2);
    chk("t5_acc3", acc[3] - acc[0], 4);
    chk("t5_write_count", log_set.size() - base, 4);
    if (log_set.size() >= base + 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t5_write_cycle_%0d", i), log_cyc[base + i] - acc[0], 2 * i + 2);

    // Asynchronous reset during READ drops the update
    base = log_set.size();
    push(32'h0000_1008, 32'h0000_2000, 1'b1, a);
    @(negedge clk);
    upd_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_wr_en", wr_en, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_upd_ready", upd_ready, 1'b1);
    #4 rst = 1'b0;
    idle(6);
    chk("t6_no_write", log_set.size() - base, 0);
    push(32'h0000_1008, 32'h0000_2000, 1'b1, a);
    idle(6);
    chk("t6_resume_count", log_set.size() - base, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
